// File: rtl/asym_fifo_6to3_pkg.sv
// Shared constants for the 6-to-3 asymmetric FIFO.
// RD_WIDTH_DEF : read nibble width; WR_WIDTH_DEF : write word width (two nibbles)
// DEPTH_DEF    : default capacity in write words; PTR_W_DEF : nibble pointer width
package asym_fifo_6to3_pkg;

   localparam int unsigned RD_WIDTH_DEF = 3;
   localparam int unsigned WR_WIDTH_DEF = 2 * RD_WIDTH_DEF;
   localparam int unsigned DEPTH_DEF    = 16;

   // Nibble-address width for a FIFO holding depth words (2*depth nibbles).
   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(2 * depth);
   endfunction

   localparam int unsigned PTR_W_DEF = ptr_w(DEPTH_DEF);

endpackage

// File: rtl/asym_fifo_mem.sv
// Nibble storage for the asymmetric FIFO: 2*DEPTH x RD_WIDTH array.
// Ports: clk, rst (sync, active-high; clears only the read register)
//        we/waddr/wdata : writes wdata MSB nibble at waddr, LSB nibble at waddr+1
//        re/raddr/rdata : registered read; rdata holds when re is low
module asym_fifo_mem
   import asym_fifo_6to3_pkg::*;
#(
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned RD_WIDTH = RD_WIDTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we,
   input  logic [ptr_w(DEPTH)-1:0]     waddr,
   input  logic [2*RD_WIDTH-1:0]       wdata,
   input  logic                        re,
   input  logic [ptr_w(DEPTH)-1:0]     raddr,
   output logic [RD_WIDTH-1:0]         rdata
);

   localparam int unsigned PTR_W = ptr_w(DEPTH);
   localparam int unsigned SLOTS = 2 * DEPTH;

   logic [RD_WIDTH-1:0] mem_q [SLOTS];
   logic [RD_WIDTH-1:0] mem_d [SLOTS];
   logic [RD_WIDTH-1:0] rdata_q;
   logic [RD_WIDTH-1:0] rdata_d;
   logic [PTR_W-1:0]    waddr_p1;

   // Second nibble slot of a word write; wraps with the pointer.
   assign waddr_p1 = PTR_W'(waddr + PTR_W'(1));

   // Next-state for the array and read register.
   always_comb begin
      mem_d   = mem_q;
      rdata_d = rdata_q;
      if (we) begin
         mem_d[waddr]    = wdata[2*RD_WIDTH-1 -: RD_WIDTH];
         mem_d[waddr_p1] = wdata[RD_WIDTH-1:0];
      end
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   // Array contents need no reset; stale data is unreachable once pointers clear.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/asym_fifo_6to3.sv
// Single-clock FIFO: 6-bit words in, 3-bit nibbles out (MSB nibble first).
// Ports: clk, rst (sync, active-high)
//        wr_en/din  : word write, accepted when !full; wr_ack pulses next cycle
//        rd_en/dout : nibble read, accepted when !empty; dout registered, 1-cycle latency
//        full       : fewer than two free nibble slots
//        empty      : no nibble stored
module asym_fifo_6to3
   import asym_fifo_6to3_pkg::*;
#(
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned RD_WIDTH = RD_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [2*RD_WIDTH-1:0] din,
   output logic                  wr_ack,
   input  logic                  rd_en,
   output logic [RD_WIDTH-1:0]   dout,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned PTR_W = ptr_w(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_THR = CNT_W'(2 * DEPTH - 2);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_ack_q, wr_ack_d;
   logic             wr_acc;
   logic             rd_acc;

   // Flags decode from registered occupancy only.
   assign empty  = (cnt_q == '0);
   assign full   = (cnt_q > FULL_THR);
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   // Pointer, occupancy and ack next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      wr_ack_d = 1'b0;
      if (wr_acc) begin
         wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(2));
         wr_ack_d = 1'b1;
      end
      if (rd_acc) begin
         rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
      end
      unique case ({wr_acc, rd_acc})
         2'b10:   cnt_d = CNT_W'(cnt_q + CNT_W'(2));
         2'b01:   cnt_d = CNT_W'(cnt_q - CNT_W'(1));
         2'b11:   cnt_d = CNT_W'(cnt_q + CNT_W'(1));
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         wr_ack_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         wr_ack_q <= wr_ack_d;
      end
   end

   assign wr_ack = wr_ack_q;

   asym_fifo_mem #(
      .DEPTH    (DEPTH),
      .RD_WIDTH (RD_WIDTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc && !rst),
      .waddr (wr_ptr_q),
      .wdata (din),
      .re    (rd_acc && !rst),
      .raddr (rd_ptr_q),
      .rdata (dout)
   );

endmodule

// File: tb/tb_asym_fifo_6to3.sv
// Self-checking bench for asym_fifo_6to3: directed scenarios plus random traffic,
// checked every cycle against a nibble-queue reference model.
module tb_asym_fifo_6to3;

   localparam int DEPTH = 16;
   localparam int SLOTS = 2 * DEPTH;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [5:0] din;
   logic       wr_ack;
   logic       rd_en;
   logic [2:0] dout;
   logic       full;
   logic       empty;

   int n_cmp;
   int n_bad;

   // Reference model: stored nibbles in FIFO order, plus expected registered outputs.
   logic [2:0] model_q[$];
   logic [2:0] dout_m;
   logic       ack_m;

   asym_fifo_6to3 #(.DEPTH(DEPTH), .RD_WIDTH(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en),
      .din    (din),
      .wr_ack (wr_ack),
      .rd_en  (rd_en),
      .dout   (dout),
      .full   (full),
      .empty  (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus (called between edges), advance the model, check after the edge.
   task automatic cycle(input bit r, input bit w, input logic [5:0] d, input bit rd);
      int occ;
      rst   = r;
      wr_en = w;
      din   = d;
      rd_en = rd;
      occ   = model_q.size();
      if (r) begin
         model_q.delete();
         dout_m = 3'd0;
         ack_m  = 1'b0;
      end else begin
         ack_m = w && (occ <= SLOTS - 2);
         if (rd && occ != 0) dout_m = model_q.pop_front();
         if (ack_m) begin
            model_q.push_back(d[5:3]);
            model_q.push_back(d[2:0]);
         end
      end
      @(negedge clk);
      check("dout",   32'(dout),   32'(dout_m));
      check("wr_ack", 32'(wr_ack), 32'(ack_m));
      check("empty",  32'(empty),  32'(model_q.size() == 0));
      check("full",   32'(full),   32'(model_q.size() > SLOTS - 2));
   endtask

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      dout_m = 3'd0;
      ack_m  = 1'b0;
      rst    = 1'b1;
      wr_en  = 1'b0;
      din    = 6'd0;
      rd_en  = 1'b0;

      // Reset state
      cycle(1, 0, 6'd0, 0);
      cycle(1, 1, 6'h3F, 1);
      check("rst_empty", 32'(empty),  32'd1);
      check("rst_full",  32'(full),   32'd0);
      check("rst_dout",  32'(dout),   32'd0);
      check("rst_ack",   32'(wr_ack), 32'd0);

      // Basic write and two nibble reads
      cycle(0, 1, 6'b101_011, 0);
      check("basic_ack",   32'(wr_ack), 32'd1);
      check("basic_empty", 32'(empty),  32'd0);
      cycle(0, 0, 6'd0, 1);
      check("basic_msb", 32'(dout), 32'b101);
      cycle(0, 0, 6'd0, 1);
      check("basic_lsb",    32'(dout),  32'b011);
      check("basic_empty2", 32'(empty), 32'd1);

      // Fill to full, overflow attempt, then single-nibble read boundary
      for (int i = 1; i <= DEPTH; i++) cycle(0, 1, 6'(i), 0);
      check("fill_full", 32'(full), 32'd1);
      cycle(0, 1, 6'h2A, 0);
      check("ovf_ack", 32'(wr_ack), 32'd0);
      cycle(0, 0, 6'd0, 1);
      check("full_after_1rd", 32'(full), 32'd1);
      cycle(0, 0, 6'd0, 1);
      check("full_after_2rd", 32'(full), 32'd0);

      // Drain and check order explicitly
      for (int i = 2; i < SLOTS; i++) begin
         logic [5:0] w;
         w = 6'((i / 2) + 1);
         cycle(0, 0, 6'd0, 1);
         check("drain_order", 32'(dout), (i % 2 == 0) ? 32'(w[5:3]) : 32'(w[2:0]));
      end
      cycle(0, 0, 6'd0, 1);
      check("empty_rd_hold", 32'(dout),  32'd0);
      check("empty_rd_emp",  32'(empty), 32'd1);

      // Writes every other cycle with continuous reads across pointer wrap
      for (int i = 0; i < 200; i++) cycle(0, (i % 2) == 0, 6'($urandom), 1);
      while (model_q.size() != 0) cycle(0, 0, 6'd0, 1);

      // Write and read together at cnt==0: read ignored
      cycle(0, 1, 6'b110_001, 1);
      check("wr_rd_empty",  32'(empty), 32'd0);
      cycle(0, 0, 6'd0, 1);
      check("wr_rd_first",  32'(dout),  32'b110);
      cycle(0, 0, 6'd0, 1);

      // Mid-operation reset discards contents
      for (int i = 0; i < 5; i++) cycle(0, 1, 6'($urandom), 0);
      cycle(1, 0, 6'd0, 0);
      check("mid_rst_empty", 32'(empty), 32'd1);
      check("mid_rst_full",  32'(full),  32'd0);
      check("mid_rst_dout",  32'(dout),  32'd0);
      cycle(0, 1, 6'b010_101, 0);
      cycle(0, 0, 6'd0, 1);
      check("post_rst_msb", 32'(dout), 32'b010);
      cycle(0, 0, 6'd0, 1);
      check("post_rst_lsb", 32'(dout), 32'b101);
      check("post_rst_emp", 32'(empty), 32'd1);

      // Random traffic with phases biased toward filling and draining
      for (int i = 0; i < 3000; i++) begin
         int  bias;
         bit  w;
         bit  rd;
         bias = ((i / 150) % 2 == 0) ? 75 : 25;
         w    = ($urandom_range(99) < bias);
         rd   = ($urandom_range(99) < (100 - bias));
         cycle(($urandom_range(299) == 0), w, 6'($urandom), rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/asym_fifo_6to3.md
Name: asym_fifo_6to3

Overview:
- Single-clock FIFO with asymmetric port widths. Each write accepts one 6-bit word, and each read returns one 3-bit nibble.
- Each written word is read back as two nibbles, most-significant nibble first.
- Buffers packet-counter words between a pulse-driven producer and an AXI-Stream style consumer that may stall.
- Standard (non-first-word-fall-through) read, with 1-cycle read latency.

Parameters:
- DEPTH, 16, capacity in 6-bit write words; must be a power of two, minimum 2. Internal storage is 2*DEPTH nibbles.
- RD_WIDTH, 3, read-port data width. Write width is fixed at 2*RD_WIDTH.

Ports:
- clk  input  1  single clock for both write and read sides.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- din  input  6  write data word.
- wr_ack  output  1  registered; high the cycle after a write is accepted.
- rd_en  input  1  read request.
- dout  output  3  registered read data nibble.
- full  output  1  high when another full word cannot be accepted.
- empty  output  1  high when no nibble is available to read.

Behaviour:
- Reset (rst=1 at posedge clk):
  - Pointers and occupancy are cleared to 0, and all contents are discarded.
  - dout=0, wr_ack=0, empty=1, full=0.
  - wr_en and rd_en are ignored that cycle. Reset mid-operation behaves identically.
- Occupancy:
  - cnt counts stored nibbles, range 0..2*DEPTH.
  - empty = (cnt==0).
  - full = (cnt > 2*DEPTH-2), i.e. fewer than two free nibble slots. A full FIFO stays full after a single nibble read.
  - Both flags decode combinationally from registered state, so they change only after a clock edge.
- Write:
  - Accepted at posedge clk when wr_en=1 and full=0.
  - din[5:3] is stored at the write pointer and din[2:0] at write pointer +1. Write pointer advances by 2 and cnt increases by 2.
  - wr_ack=1 in the following cycle, otherwise 0.
  - Write while full: ignored, no state change, wr_ack=0 next cycle.
- Read:
  - Accepted at posedge clk when rd_en=1 and empty=0.
  - dout takes the nibble at the read pointer on that edge (valid the cycle after rd_en). Read pointer advances by 1 and cnt decreases by 1.
  - Read while empty: ignored, dout holds its previous value.
  - dout holds its value whenever no read is accepted.
- Latency:
  - A write at edge N makes empty=0 after edge N.
  - The earliest read edge is N+1, with the first nibble on dout after that edge.
- Simultaneous read and write: both are accepted independently against the pre-edge flags.
  - Net cnt change is +1.
  - Write while cnt==0 and read in the same cycle: the read is ignored, since empty was 1.
- Pointer arithmetic:
  - Pointers are log2(2*DEPTH) bits and wrap modulo 2*DEPTH.
  - The write pointer is always even.
  - Word order is preserved, and nibble order within a word is MSB first.
- Storage: a simple register or RAM array. No read-during-write bypass is needed, since empty gating prevents same-slot hazards.

Decomposition:
- Shared package:
  - RD_WIDTH constant and derived WR_WIDTH = 2*RD_WIDTH.
  - DEPTH default.
  - Helper constant PTR_W = $clog2(2*DEPTH).
- One natural sub-module: asym_fifo_mem, a 2*DEPTH x RD_WIDTH array with a dual-nibble write port and a single registered read port.
- Flag and pointer logic stays in the top-level module.

Test Plan:
- Reset state: assert rst 2 cycles -> empty=1, full=0, wr_ack=0, dout=0.
- Basic write/read: write din=6'b101_011 (0x2B) once.
  - wr_ack=1 the next cycle and empty=0.
  - Read twice: dout=3'b101 then 3'b011, each one cycle after its rd_en; empty=1 after the second read.
- Fill to full with DEPTH=16: write words 1..16.
  - full=1 after the 16th write; a 17th write gives wr_ack=0 and the contents are unchanged.
  - Read one nibble -> full stays 1. Read a second nibble -> full=0.
- Drain and order check: read all 32 nibbles -> sequence {1>>3,1&7,2>>3,2&7,...}.
  - Then a read while empty leaves dout holding the last value (3'b000 for word 16), and cnt stays 0.
- Simultaneous traffic:
  - Continuous writes every other cycle with continuous reads; no loss or duplication across pointer wrap over 100 words.
  - Write+read in the same cycle with cnt==0 -> the read is ignored and empty=0 next cycle.
- Mid-operation reset: after 5 writes assert rst -> empty=1, full=0, dout=0. A subsequent write/read returns only the new data.
